inv_round_tail: RTL
===================

INV_ROUND_TAIL -- requirements
Module: inv_round_tail

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream offers a state/key pair.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 state_in  input  128  state from InvSubBytes stage; byte k = state_in[8k:8k+7], byte 0 = bits [0:7].
REQ-007 round_key  input  128  round key, same byte ordering as state_in.
REQ-008 last_round  input  1  sampled with the pair; 1 = skip InvMixColumns.
REQ-009 out_valid  output  1  state_out holds a finished result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 state_out  output  128  AddRoundKey/InvMixColumns result; ordering as state_in; registered.

Function
REQ-012 The block SHALL have one state register with states IDLE, MIX0, MIX1, MIX2, MIX3, DONE.
REQ-013 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only; both SHALL be combinational decodes of the state.
REQ-014 Accept = in_valid & in_ready; on accept the block SHALL load work = state_in XOR round_key, latch last_round, and go to MIX0 (last_round=0) or DONE (last_round=1).
REQ-015 In MIXi (i=0..3) the block SHALL replace column i (bytes 4i..4i+3 = a0..a3) with InvMixColumns, then go to MIX(i+1), or DONE after MIX3.
REQ-016 InvMixColumns: b0=0e*a0^0b*a1^0d*a2^09*a3; b1=09*a0^0e*a1^0b*a2^0d*a3; b2=0d*a0^09*a1^0e*a2^0b*a3; b3=0b*a0^0d*a1^09*a2^0e*a3.
REQ-017 "*" SHALL be GF(2^8) multiplication modulo x^8+x^4+x^3+x+1 (0x11B), built from xtime; results exactly 8 bits.
REQ-018 Exactly one column SHALL be transformed per MIX cycle; other columns SHALL hold.
REQ-019 Latency SHALL be 5 clocks from the accept edge to out_valid=1 with last_round=0, and 1 clock with last_round=1.
REQ-020 state_out SHALL equal work in DONE and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 In DONE, out_ready=1 SHALL return to IDLE on the next edge; state_out SHALL keep its value until the next result.
REQ-022 in_valid outside IDLE SHALL be ignored; state_in, round_key and last_round SHALL NOT be sampled except on accept.
REQ-023 out_ready outside DONE SHALL be ignored; a new pair SHALL NOT be accepted in the same cycle a result is consumed.
REQ-024 Changing state_in/round_key/last_round during MIX or DONE SHALL NOT affect the result in progress.

Reset
REQ-025 reset_n=0 SHALL immediately, without waiting for clk, force state IDLE, work and state_out to 0, latched last_round to 0, giving in_ready=1 and out_valid=0.
REQ-026 Reset asserted in any state, including mid-MIX, SHALL abandon the operation with no output produced.
REQ-027 After reset_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-028 Reset: assert reset_n=0 with no clock -> in_ready=1, out_valid=0, state_out=0 immediately.
REQ-029 Mix path: state_in={8e4da1bc}x4, round_key=0, last_round=0 -> out_valid=1 five clocks after accept, state_out={db135345}x4.
REQ-030 Key before mix: state_in=0, round_key={8e4da1bc}x4, last_round=0 -> state_out={db135345}x4; with {01010101}x4 in place of {8e4da1bc}x4 -> {01010101}x4.
REQ-031 Final round: state_in=00112233445566778899aabbccddeeff, round_key=000102030405060708090a0b0c0d0e0f, last_round=1 -> one clock later state_out=00102030405060708090a0b0c0d0e0f0.
REQ-032 Backpressure: hold out_ready=0 for 3 clocks in DONE and pulse in_valid with new data -> out_valid and state_out stable, no accept; out_ready=1 -> IDLE next clock.
REQ-033 Mid-operation reset: assert reset_n in MIX2 -> IDLE, state_out=0, no out_valid; a following accept completes normally.

Source files
------------

// File: rtl/inv_round_tail_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inv_round_tail_if                                                |
// | Handshake and data bundle for the AES inverse-round tail stage.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface inv_round_tail_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, round_key, last_round, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, round_key, last_round, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface
`default_nettype wire

// File: rtl/inv_round_tail.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inv_round_tail                                                   |
// | AddRoundKey followed by column-serial InvMixColumns (1 col/clk). |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module inv_round_tail (
    input  logic             clk,
    input  logic             reset_n,
    inv_round_tail_if.slave  bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MIX0 = 3'd1;
    localparam logic [2:0] c_MIX1 = 3'd2;
    localparam logic [2:0] c_MIX2 = 3'd3;
    localparam logic [2:0] c_MIX3 = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    logic [2:0]   r_state;
    logic [127:0] r_work;
    logic [127:0] r_out;
    logic         r_last;

    logic [127:0] w_keyed;
    logic [31:0]  w_col;
    logic [31:0]  w_mixed;
    logic [127:0] w_work_nxt;
    logic         w_mix_en;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column packs a0 in the top byte, matching byte 0 at the MSB end of the state.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [3:0][7:0] a, m2, m4, m8, m9, mb, md, me;
        a = c;
        for (int i = 0; i < 4; i++) begin
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        // a[3] is a0 (top byte), a[0] is a3
        return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
                m9[3] ^ me[2] ^ mb[1] ^ md[0],
                md[3] ^ m9[2] ^ me[1] ^ mb[0],
                mb[3] ^ md[2] ^ m9[1] ^ me[0]};
    endfunction

    assign w_keyed  = bus.state_in ^ bus.round_key;
    assign w_mix_en = ~r_last;

    always_comb begin
        w_col = r_work[127:96];
        case (r_state)
            c_MIX1:  w_col = r_work[95:64];
            c_MIX2:  w_col = r_work[63:32];
            c_MIX3:  w_col = r_work[31:0];
            default: w_col = r_work[127:96];
        endcase
    end

    assign w_mixed = inv_mix_col(w_col);

    // Only the column owned by the current MIX state changes.
    always_comb begin
        w_work_nxt = r_work;
        if (w_mix_en) begin
            case (r_state)
                c_MIX0:  w_work_nxt[127:96] = w_mixed;
                c_MIX1:  w_work_nxt[95:64]  = w_mixed;
                c_MIX2:  w_work_nxt[63:32]  = w_mixed;
                c_MIX3:  w_work_nxt[31:0]   = w_mixed;
                default: w_work_nxt = r_work;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_work  <= '0;
            r_out   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_work <= w_keyed;
                        r_last <= bus.last_round;
                        if (bus.last_round) begin
                            r_out   <= w_keyed;
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_MIX0;
                        end
                    end
                end
                c_MIX0: begin
                    r_work  <= w_work_nxt;
                    r_state <= c_MIX1;
                end
                c_MIX1: begin
                    r_work  <= w_work_nxt;
                    r_state <= c_MIX2;
                end
                c_MIX2: begin
                    r_work  <= w_work_nxt;
                    r_state <= c_MIX3;
                end
                c_MIX3: begin
                    r_work  <= w_work_nxt;
                    r_out   <= w_work_nxt;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.state_out = r_out;

endmodule
`default_nettype wire
